speed_button_conditioner: RTL and testbench

- Upstream stage of the speed-goal register: turns two raw active-low pushbuttons into clean single-cycle up/down step pulses.
- Per button: 2-flop synchronizer, then debounce filter, then press/hold/auto-repeat state machine.
- Cross-button lockout keeps up and down mutually exclusive.
- Outputs drive the goal stepper's up/down inputs directly, one step per pulse.

---
 rtl/speed_button_conditioner_if.sv | 27 ++
 rtl/speed_button_conditioner.sv | 160 ++++++++++++++++
 tb/tb_speed_button_conditioner.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/speed_button_conditioner_if.sv
// Button-side bundle of the speed-goal input conditioner: raw active-low keys in,
// clean single-cycle step pulses and a "button held" level out.
interface speed_button_conditioner_if;
    logic key_up_n;
    logic key_down_n;
    logic up;
    logic down;
    logic pressed;

    // Drives the raw keys and observes the conditioned outputs.
    modport master (
        output key_up_n,
        output key_down_n,
        input  up,
        input  down,
        input  pressed
    );

    // The conditioner itself.
    modport slave (
        input  key_up_n,
        input  key_down_n,
        output up,
        output down,
        output pressed
    );
endinterface

// File: rtl/speed_button_conditioner.sv
// Speed-goal button conditioner: per key a 2-flop synchronizer, a debounce
// filter and a press/hold/auto-repeat FSM. Channel 0 is "up" and channel 1 is
// "down". While both debounced keys are held, both channels sit in a lockout
// state that suppresses all pulses until each channel's own key is released.
module speed_button_conditioner #(
    parameter int CNT_W           = 25,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_DELAY      = 25000000,
    parameter int REPEAT_PERIOD   = 2500000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    speed_button_conditioner_if.slave   bus
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_REPEAT,
        S_LOCK
    } state_e;

    // Synchronizer: bit 0 = up key, bit 1 = down key, still active-low here.
    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    logic [1:0]       key_act;

    // Debounced active-high key levels and their stability counters.
    logic [1:0]       db_q, db_d;
    logic [CNT_W-1:0] db_cnt_q [2];
    logic [CNT_W-1:0] db_cnt_d [2];

    // Per-channel press FSM, hold/repeat timer and registered step pulse.
    state_e           state_q [2];
    state_e           state_d [2];
    logic [CNT_W-1:0] tmr_q [2];
    logic [CNT_W-1:0] tmr_d [2];
    logic [1:0]       pulse_q, pulse_d;
    logic             pressed_q, pressed_d;
    logic             both_held;

    assign key_act   = ~sync2_q;
    assign both_held = db_q[0] & db_q[1];

    // Two-stage synchronizer feed for the asynchronous raw keys.
    always_comb begin
        sync1_d = {bus.key_down_n, bus.key_up_n};
        sync2_d = sync1_q;
    end

    // Debounce: a level change is accepted only after DEBOUNCE_CYCLES
    // consecutive disagreeing samples; any agreeing sample restarts the run.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (key_act[i] == db_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_d[i]     = key_act[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Press FSM: one pulse on press, one after HOLD_DELAY, then one every
    // REPEAT_PERIOD; both keys held forces lockout with no pulse that edge.
    always_comb begin
        pressed_d = |db_q;
        pulse_d   = '0;
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            tmr_d[i]   = tmr_q[i];
            if (both_held) begin
                state_d[i] = S_LOCK;
                tmr_d[i]   = '0;
            end else begin
                case (state_q[i])
                    S_IDLE: begin
                        if (db_q[i]) begin
                            pulse_d[i] = 1'b1;
                            tmr_d[i]   = '0;
                            state_d[i] = S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (!db_q[i]) begin
                            tmr_d[i]   = '0;
                            state_d[i] = S_IDLE;
                        end else if (tmr_q[i] == HOLD_LAST) begin
                            pulse_d[i] = 1'b1;
                            tmr_d[i]   = '0;
                            state_d[i] = S_REPEAT;
                        end else begin
                            tmr_d[i] = tmr_q[i] + CNT_ONE;
                        end
                    end
                    S_REPEAT: begin
                        if (!db_q[i]) begin
                            tmr_d[i]   = '0;
                            state_d[i] = S_IDLE;
                        end else if (tmr_q[i] == REP_LAST) begin
                            pulse_d[i] = 1'b1;
                            tmr_d[i]   = '0;
                        end else begin
                            tmr_d[i] = tmr_q[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        // Lockout: a still-held key never re-fires; it must
                        // be released before the channel can arm again.
                        tmr_d[i] = '0;
                        if (!db_q[i]) begin
                            state_d[i] = S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    // State registers; reset returns everything to the released/idle state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            db_q      <= 2'b00;
            pulse_q   <= 2'b00;
            pressed_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
                tmr_q[i]    <= '0;
                state_q[i]  <= S_IDLE;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            pulse_q   <= pulse_d;
            pressed_q <= pressed_d;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
                tmr_q[i]    <= tmr_d[i];
                state_q[i]  <= state_d[i];
            end
        end
    end

    assign bus.up      = pulse_q[0];
    assign bus.down    = pulse_q[1];
    assign bus.pressed = pressed_q;

endmodule

// File: tb/tb_speed_button_conditioner.sv
// Bench for speed_button_conditioner with small timing parameters. A
// behavioural model (delay line, sample-window debounce, age-based pulse rule)
// is compared against the DUT every cycle; pulse/pressed timestamps taken from
// the DUT are also checked against hand-computed cycle numbers.
module tb_speed_button_conditioner;

    localparam int DB   = 4;
    localparam int HOLD = 20;
    localparam int REP  = 5;

    logic clk;
    logic rst_n;
    speed_button_conditioner_if bus ();

    speed_button_conditioner #(
        .CNT_W          (8),
        .DEBOUNCE_CYCLES(DB),
        .HOLD_DELAY     (HOLD),
        .REPEAT_PERIOD  (REP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    int up_log[$];
    int dn_log[$];
    int none[$];
    int press_rise = -1;
    int press_fall = -1;
    logic prev_pressed = 1'b0;

    task automatic chk(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic chk_list(input string name, input int got[$], input int want[$]);
        chk($sformatf("%s count", name), got.size(), want.size());
        for (int i = 0; i < got.size() && i < want.size(); i++)
            chk($sformatf("%s[%0d]", name, i), got[i], want[i]);
    endtask

    // ---------------- behavioural model ----------------
    logic [1:0]    m_s1, m_s2;
    logic [1:0]    m_db;
    logic [DB-1:0] m_hist [2];
    bit   [1:0]    m_locked, m_active;
    int            m_age [2];
    logic [1:0]    m_pulse;
    logic          m_pressed;

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = 2'b11; m_s2 = 2'b11; m_db = 2'b00;
            m_locked = '0; m_active = '0; m_pulse = '0; m_pressed = 1'b0;
            for (int c = 0; c < 2; c++) begin
                m_hist[c] = '0;
                m_age[c]  = 0;
            end
        end else begin
            bit both;
            both = m_db[0] && m_db[1];
            for (int c = 0; c < 2; c++) begin
                m_pulse[c] = 1'b0;
                if (both) begin
                    m_locked[c] = 1'b1;
                    m_active[c] = 1'b0;
                end else if (m_locked[c]) begin
                    if (!m_db[c]) m_locked[c] = 1'b0;
                end else if (!m_db[c]) begin
                    m_active[c] = 1'b0;
                end else if (!m_active[c]) begin
                    m_pulse[c]  = 1'b1;
                    m_active[c] = 1'b1;
                    m_age[c]    = 0;
                end else begin
                    m_age[c]++;
                    if (m_age[c] == HOLD || (m_age[c] > HOLD && (m_age[c] - HOLD) % REP == 0))
                        m_pulse[c] = 1'b1;
                end
            end
            m_pressed = m_db[0] | m_db[1];
            for (int c = 0; c < 2; c++) begin
                m_hist[c] = {m_hist[c][DB-2:0], ~m_s2[c]};
                if (m_hist[c] == {DB{~m_db[c]}}) m_db[c] = ~m_db[c];
            end
            m_s2 = m_s1;
            m_s1 = {bus.key_down_n, bus.key_up_n};
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("up", int'(bus.up), int'(m_pulse[0]));
            chk("down", int'(bus.down), int'(m_pulse[1]));
            chk("pressed", int'(bus.pressed), int'(m_pressed));
            if (bus.up === 1'b1) up_log.push_back(cyc);
            if (bus.down === 1'b1) dn_log.push_back(cyc);
            if (bus.pressed === 1'b1 && prev_pressed !== 1'b1) press_rise = cyc;
            if (bus.pressed !== 1'b1 && prev_pressed === 1'b1) press_fall = cyc;
            prev_pressed = bus.pressed;
        end
    end

    // Advance to just after the falling edge that follows rising edge k.
    task automatic at(input int k);
        while (cyc < k) @(negedge clk);
        #1;
    endtask

    task automatic start_test();
        @(negedge clk);
        #1;
        cyc = 0;
        up_log.delete();
        dn_log.delete();
        press_rise = -1;
        press_fall = -1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.key_up_n   = 1'b1;
        bus.key_down_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset up", int'(bus.up), 0);
        chk("reset down", int'(bus.down), 0);
        chk("reset pressed", int'(bus.pressed), 0);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        repeat (5) @(negedge clk);

        // Clean press on up.
        start_test();
        bus.key_up_n = 1'b0;
        at(10); bus.key_up_n = 1'b1;
        at(35);
        chk_list("clean up", up_log, '{7});
        chk_list("clean down", dn_log, none);
        chk("clean press_rise", press_rise, 7);
        chk("clean press_fall", press_fall, 17);

        // Bouncing up key, then stable low from cycle 12.
        start_test();
        bus.key_up_n = 1'b0;
        at(2);  bus.key_up_n = 1'b1;
        at(4);  bus.key_up_n = 1'b0;
        at(6);  bus.key_up_n = 1'b1;
        at(8);  bus.key_up_n = 1'b0;
        at(10); bus.key_up_n = 1'b1;
        at(12); bus.key_up_n = 1'b0;
        at(20); bus.key_up_n = 1'b1;
        at(45);
        chk_list("bounce up", up_log, '{19});
        chk_list("bounce down", dn_log, none);

        // Auto-repeat on down; debounced release lands at edge 66.
        start_test();
        bus.key_down_n = 1'b0;
        at(60); bus.key_down_n = 1'b1;
        at(90);
        chk_list("repeat down", dn_log, '{7, 27, 32, 37, 42, 47, 52, 57, 62});
        chk_list("repeat up", up_log, none);

        // Lockout, then a fresh down press after both are released.
        start_test();
        bus.key_up_n = 1'b0;
        at(10); bus.key_down_n = 1'b0;
        at(30); bus.key_up_n   = 1'b1;
        at(50); bus.key_down_n = 1'b1;
        at(70); bus.key_down_n = 1'b0;
        at(75); bus.key_down_n = 1'b1;
        at(100);
        chk_list("lock up", up_log, '{7});
        chk_list("lock down", dn_log, '{77});

        // Simultaneous press.
        start_test();
        bus.key_up_n   = 1'b0;
        bus.key_down_n = 1'b0;
        at(10);
        bus.key_up_n   = 1'b1;
        bus.key_down_n = 1'b1;
        at(35);
        chk_list("simul up", up_log, none);
        chk_list("simul down", dn_log, none);
        chk("simul press_rise", press_rise, 7);

        // Asynchronous reset while up is in auto-repeat with a pulse showing.
        start_test();
        bus.key_up_n = 1'b0;
        at(37);
        chk_list("prereset up", up_log, '{7, 27, 32, 37});
        chk("up before reset", int'(bus.up), 1);
        rst_n = 1'b0;
        #1;
        chk("reset mid up", int'(bus.up), 0);
        chk("reset mid down", int'(bus.down), 0);
        chk("reset mid pressed", int'(bus.pressed), 0);
        at(40);
        rst_n = 1'b1;
        cyc = 0;
        up_log.delete();
        dn_log.delete();
        at(35); bus.key_up_n = 1'b1;
        at(60);
        chk_list("postreset up", up_log, '{7, 27, 32, 37});
        chk_list("postreset down", dn_log, none);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
